// File: rtl/knn_seq.sv
// knn_seq: sequences training-point fetches and distance-core strobes for one k-NN pass
module knn_seq #(
    parameter int DATA_W = 32,
    parameter int LABEL  = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] n_points,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] b_data,
    output logic [LABEL-1:0]  label,
    output logic              rst_acc,
    output logic              en_acc,
    output logic              sel_xy,
    output logic              en_reg,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] point_cnt
);
    typedef enum logic [2:0] {IDLE, FETCH_D, FETCH_L, CLR, ACC_X, ACC_Y, UPD, DONE} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] base, n, k, last;
    logic go;
    assign last = n - 1'b1;
    assign go = state == IDLE && start && !abort && n_points != '0;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            base   <= '0;
            n      <= '0;
            k      <= '0;
            b_data <= '0;
            label  <= '0;
        end else begin
            state <= state_nx;
            if (go) begin
                base <= base_addr;
                n    <= n_points;
                k    <= '0;
            end
            if (!abort && mem_ack && state == FETCH_D) b_data <= mem_rdata;
            if (!abort && mem_ack && state == FETCH_L) label <= mem_rdata[LABEL-1:0];
            if (!abort && state == UPD && k != last) k <= k + 1'b1;
        end
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = n_points == '0 ? DONE : FETCH_D;
            FETCH_D: if (mem_ack) state_nx = FETCH_L;
            FETCH_L: if (mem_ack) state_nx = CLR;
            CLR:     state_nx = ACC_X;
            ACC_X:   state_nx = ACC_Y;
            ACC_Y:   state_nx = UPD;
            UPD:     state_nx = k == last ? DONE : FETCH_D;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end
    assign mem_req   = state == FETCH_D || state == FETCH_L;
    assign mem_addr  = base + (k << 1) + ADDR_W'(state == FETCH_L);
    assign rst_acc   = state == CLR;
    assign en_acc    = state == ACC_X || state == ACC_Y;
    assign sel_xy    = state == ACC_Y;
    assign en_reg    = state == UPD;
    assign valid     = state == UPD;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign point_cnt = k;
endmodule

// File: tb/tb_knn_seq.sv
// tb_knn_seq: table-driven and randomized passes checked cycle by cycle against a schedule model
module tb_knn_seq;
    logic        clk = 0;
    logic        rst, start, abort, mem_ack;
    logic [9:0]  base_addr, n_points, mem_addr, point_cnt;
    logic [31:0] mem_rdata, b_data;
    logic [7:0]  label;
    logic        mem_req, rst_acc, en_acc, sel_xy, en_reg, valid, busy, done;

    knn_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .n_points(n_points),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .b_data(b_data), .label(label),
        .rst_acc(rst_acc), .en_acc(en_acc), .sel_xy(sel_xy), .en_reg(en_reg), .valid(valid),
        .busy(busy), .done(done), .point_cnt(point_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] base;
        logic [9:0] n;
        int         dly;
        bit         rnd;
        int         abort_pt;
        bit         junk;
        logic [9:0] first;
        logic [9:0] last;
    } rec_t;

    rec_t tbl[7];
    int vecs = 0, errs = 0;
    logic [9:0]  mk;
    logic [31:0] mb;
    logic [7:0]  ml;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // strobe order: rst_acc, en_acc, sel_xy, en_reg, valid
    task automatic chk_out(input string nm, input bit req, input logic [9:0] addr,
                           input logic [4:0] strb, input bit bsy, input bit dn);
        chk(nm, {mem_req, req ? mem_addr : 10'h0, rst_acc, en_acc, sel_xy, en_reg, valid, busy, done, point_cnt},
                {req, req ? addr : 10'h0, strb, bsy, dn, mk});
    endtask

    task automatic chk_hold(input string nm);
        chk({nm, "_bdata"}, b_data, mb);
        chk({nm, "_label"}, label, ml);
    endtask

    task automatic noise;
        mem_ack = 1'($urandom);
        mem_rdata = $urandom;
    endtask

    task automatic idle_gap(input int c);
        for (int i = 0; i < c; i++) begin
            noise();
            start = 0;
            cyc();
            chk_out("idle_gap", 0, 0, 0, 0, 0);
            chk_hold("idle_gap");
        end
        mem_ack = 0;
    endtask

    task automatic run_pass(input rec_t r);
        logic [9:0]  a, first_a, last_a;
        logic [31:0] x;
        int d;
        first_a = 0;
        last_a = 0;
        x = 0;
        base_addr = r.base;
        n_points = r.n;
        start = 1;
        mem_ack = 0;
        cyc();
        start = 0;
        base_addr = 10'($urandom);
        n_points = 10'($urandom);
        if (r.n == 0) begin
            chk_out("n0_done", 0, 0, 0, 1, 1);
            noise();
            cyc();
            chk_out("n0_idle", 0, 0, 0, 0, 0);
            return;
        end
        mk = 0;
        for (int p = 0; p < int'(r.n); p++) begin
            for (int ph = 0; ph < 2; ph++) begin
                a = r.base + 10'(2 * p + ph);
                d = r.rnd ? $urandom_range(0, r.dly) : r.dly;
                for (int w = 0; w <= d; w++) begin
                    chk_out(ph != 0 ? "fetch_l" : "fetch_d", 1, a, 0, 1, 0);
                    if (p == 0 && ph == 0 && w == 0) first_a = mem_addr;
                    last_a = mem_addr;
                    if (r.junk && p == 0 && ph == 0 && w == 0) start = 1;
                    x = $urandom;
                    mem_rdata = x;
                    mem_ack = (w == d);
                    cyc();
                    start = 0;
                end
                if (ph == 0) mb = x;
                else ml = x[7:0];
                mem_ack = 0;
            end
            chk_hold("fetch");
            chk_out("clr", 0, 0, 5'b10000, 1, 0);
            noise();
            cyc();
            chk_out("acc_x", 0, 0, 5'b01000, 1, 0);
            noise();
            if (p == r.abort_pt) begin
                abort = 1;
                cyc();
                abort = 0;
                chk_out("abort_idle", 0, 0, 0, 0, 0);
                chk_hold("abort");
                return;
            end
            cyc();
            chk_out("acc_y", 0, 0, 5'b01100, 1, 0);
            noise();
            cyc();
            chk_out("upd", 0, 0, 5'b00011, 1, 0);
            noise();
            cyc();
            if (p < int'(r.n) - 1) mk = mk + 1'b1;
        end
        chk_out("done", 0, 0, 0, 1, 1);
        noise();
        cyc();
        chk_out("post_done", 0, 0, 0, 0, 0);
        chk_hold("post_done");
        chk("first_addr", first_a, r.first);
        chk("last_addr", last_a, r.last);
    endtask

    initial begin
        rec_t r;
        tbl[0] = '{10'h010, 10'd2, 0, 1'b0, -1, 1'b0, 10'h010, 10'h013};
        tbl[1] = '{10'h3FE, 10'd2, 0, 1'b0, -1, 1'b0, 10'h3FE, 10'h001};
        tbl[2] = '{10'h000, 10'd0, 0, 1'b0, -1, 1'b0, 10'h000, 10'h000};
        tbl[3] = '{10'h010, 10'd2, 3, 1'b0, -1, 1'b0, 10'h010, 10'h013};
        tbl[4] = '{10'h080, 10'd3, 0, 1'b0,  1, 1'b0, 10'h080, 10'h085};
        tbl[5] = '{10'h100, 10'd1, 0, 1'b0, -1, 1'b0, 10'h100, 10'h101};
        tbl[6] = '{10'h3FF, 10'd3, 2, 1'b1, -1, 1'b0, 10'h3FF, 10'h004};
        rst = 0; start = 0; abort = 0; mem_ack = 0; mem_rdata = 0;
        base_addr = 0; n_points = 0;
        mk = 0; mb = 0; ml = 0;
        cyc();
        cyc();
        chk_out("reset", 0, 0, 0, 0, 0);
        chk_hold("reset");
        rst = 1;
        idle_gap(2);
        foreach (tbl[i]) begin
            run_pass(tbl[i]);
            idle_gap(2);
        end
        for (int i = 0; i < 10; i++) begin
            r.base = 10'($urandom);
            r.n = 10'($urandom_range(1, 4));
            r.dly = $urandom_range(0, 2);
            r.rnd = 1'b1;
            r.abort_pt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(r.n) - 1)) : -1;
            r.junk = 1'($urandom);
            r.first = r.base;
            r.last = r.base + 10'(2 * int'(r.n) - 1);
            run_pass(r);
            idle_gap($urandom_range(1, 3));
        end
        // start together with abort in IDLE must stay idle
        base_addr = 10'h055;
        n_points = 10'd2;
        start = 1;
        abort = 1;
        cyc();
        start = 0;
        abort = 0;
        chk_out("start_abort_idle", 0, 0, 0, 0, 0);
        idle_gap(1);
        // reset while a label fetch is outstanding
        base_addr = 10'h020;
        n_points = 10'd3;
        start = 1;
        cyc();
        start = 0;
        mk = 0;
        chk_out("rst_fetch_d", 1, 10'h020, 0, 1, 0);
        mem_ack = 1;
        mem_rdata = 32'hCAFE_F00D;
        cyc();
        mem_ack = 1;
        mem_rdata = 32'h1234_5678;
        chk_out("rst_fetch_l", 1, 10'h021, 0, 1, 0);
        rst = 0;
        cyc();
        rst = 1;
        mem_ack = 0;
        mk = 0; mb = 0; ml = 0;
        chk_out("rst_mid_pass", 0, 0, 0, 0, 0);
        chk("rst_mem_addr", mem_addr, 10'h000);
        chk_hold("rst_mid_pass");
        idle_gap(1);
        r = '{10'h040, 10'd2, 0, 1'b0, -1, 1'b1, 10'h040, 10'h043};
        run_pass(r);
        idle_gap(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/knn_seq.md
KNN_SEQ -- requirements
Module: knn_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the training-point word and of b_data.
REQ-002 SHALL have parameter LABEL, default 8, width of the training label.
REQ-003 SHALL have parameter ADDR_W, default 10, width of the training-memory address and of the point count.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous reset, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a pass; honoured only in IDLE.
REQ-007 SHALL have port abort  input  1  terminate the current pass.
REQ-008 SHALL have port base_addr  input  ADDR_W  training-set base address, sampled on an accepted start.
REQ-009 SHALL have port n_points  input  ADDR_W  number of training points, sampled on an accepted start.
REQ-010 SHALL have port mem_req  output  1  memory read request.
REQ-011 SHALL have port mem_addr  output  ADDR_W  memory read address.
REQ-012 SHALL have port mem_ack  input  1  memory response; mem_rdata is valid in the same cycle.
REQ-013 SHALL have port mem_rdata  input  DATA_W  memory read data.
REQ-014 SHALL have port b_data  output  DATA_W  latched training coordinates driven to the cores' B input.
REQ-015 SHALL have port label  output  LABEL  latched training label, taken from mem_rdata[LABEL-1:0].
REQ-016 SHALL have core-strobe ports rst_acc, en_acc, sel_xy, en_reg, valid  output  1 each  distance-datapath strobes.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at normal pass completion.
REQ-019 SHALL have port point_cnt  output  ADDR_W  index k of the point currently being processed.

Function
REQ-020 SHALL implement states IDLE, FETCH_D, FETCH_L, CLR, ACC_X, ACC_Y, UPD and DONE.
REQ-021 SHALL, on start in IDLE with n_points!=0, latch base_addr and n_points, clear k and enter FETCH_D; with n_points==0 it SHALL enter DONE directly and issue no mem_req.
REQ-022 SHALL, in FETCH_D, drive mem_req=1 with mem_addr=base+2k; on mem_ack it SHALL load b_data<=mem_rdata and go to FETCH_L.
REQ-023 SHALL, in FETCH_L, drive mem_req=1 with mem_addr=base+2k+1; on mem_ack it SHALL load label<=mem_rdata[LABEL-1:0] and go to CLR.
REQ-024 SHALL hold mem_req and mem_addr stable until mem_ack, with no timeout; mem_ack outside FETCH_D/FETCH_L SHALL be ignored.
REQ-025 SHALL compute address arithmetic modulo 2^ADDR_W (wrap-around, no error).
REQ-026 SHALL drive rst_acc=1 in CLR, then go to ACC_X.
REQ-027 SHALL drive en_acc=1, sel_xy=0 in ACC_X, then go to ACC_Y.
REQ-028 SHALL drive en_acc=1, sel_xy=1 in ACC_Y, then go to UPD.
REQ-029 SHALL drive en_reg=1, valid=1 in UPD; then if k==n_points-1 it SHALL go to DONE, else increment k and go to FETCH_D.
REQ-030 SHALL, in DONE, drive done=1 for exactly one cycle and return to IDLE.
REQ-031 SHALL keep all strobes 0 in every state except the one that asserts them; outputs SHALL be registered or decoded from the state register only.
REQ-032 SHALL have a minimum latency of 6 cycles per point with zero-wait memory; a pass SHALL last 6*n_points+1 cycles from start to done.
REQ-033 SHALL, when abort=1 in any non-IDLE state, enter IDLE the next cycle with done=0 and no further strobes; abort SHALL take priority over every other transition.
REQ-034 SHALL ignore start while busy; start and abort together in IDLE SHALL leave the block in IDLE.
REQ-035 SHALL keep b_data, label and point_cnt holding their last values in IDLE.

Reset
REQ-036 SHALL, while rst==0 at a clock edge, set state=IDLE, k=0, b_data=0, label=0 and all 1-bit outputs 0.
REQ-037 SHALL apply reset mid-pass identically, including during an outstanding mem_req, with no done pulse.

Verification
REQ-038 SHALL be covered by: base=0x010, n=2, zero-wait ack -> addresses 0x010,0x011,0x012,0x013 in order; strobes CLR,ACC_X,ACC_Y,UPD per point; done exactly 13 cycles after start.
REQ-039 SHALL be covered by: ack delayed 3 cycles in FETCH_D -> mem_addr stable for 4 cycles, no core strobe in that window, b_data equals rdata at ack.
REQ-040 SHALL be covered by: base=0x3FE, n=2, ADDR_W=10 -> addresses 0x3FE,0x3FF,0x000,0x001.
REQ-041 SHALL be covered by: n=0 start -> busy for 1 cycle, done pulse, no mem_req.
REQ-042 SHALL be covered by: abort in ACC_X of point 1 -> IDLE next cycle, no done, no en_reg for point 1; a following start works normally.
REQ-043 SHALL be covered by: rst=0 during FETCH_L, then start pulsed while busy on a new pass -> all outputs 0 after reset; the busy-time start is ignored and point_cnt is unaffected.
